apb_master_param: RTL and testbench

- Parametrised APB4 master: accepts one command over a valid/ready interface, runs the APB SETUP/ACCESS sequence, returns read data and error status over a valid/ready response interface.
- Generalises the fixed 32-bit, 2-bit-command APB master with:
  - configurable address/data width;
  - byte strobes;
  - PSLVERR capture;
  - an ACCESS-phase timeout;
  - response backpressure.
- Sits between a local controller and an APB peripheral bus.

---
 rtl/apb_master_param_if.sv | 45 ++++
 rtl/apb_master_param.sv | 127 ++++++++++++
 tb/tb_apb_master_param.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_param_if.sv
// Command, response and APB bus bundle for apb_master_param.
// The master modport is the DUT view; slave is the controller/peripheral side.
interface apb_master_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic [STRB_W-1:0] cmd_strb_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;

  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [STRB_W-1:0] pstrb_o;
  logic              pready_i;
  logic [DATA_W-1:0] prdata_i;
  logic              pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output rsp_ready_i, pready_i, prdata_i, pslverr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/apb_master_param.sv
// Parametrised APB4 master: one command in, SETUP/ACCESS on APB, one response out.
// Supports byte strobes, PSLVERR capture, an ACCESS timeout and response backpressure.
module apb_master_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  apb_master_param_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q, rsp_to_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic [STRB_W-1:0] pstrb_q;

  logic              pwrite_nxt, rsp_err_nxt, rsp_to_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic [STRB_W-1:0] pstrb_nxt;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    paddr_nxt     = paddr_q;
    pwrite_nxt    = pwrite_q;
    pwdata_nxt    = pwdata_q;
    pstrb_nxt     = pstrb_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_err_nxt   = rsp_err_q;
    rsp_to_nxt    = rsp_to_q;

    unique case (state)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          state_nxt  = SETUP;
          paddr_nxt  = bus.cmd_addr_i;
          pwrite_nxt = bus.cmd_write_i;
          // Reads drive no strobes and leave the old write data on the bus.
          if (bus.cmd_write_i) begin
            pwdata_nxt = bus.cmd_wdata_i;
            pstrb_nxt  = bus.cmd_strb_i;
          end else begin
            pstrb_nxt  = '0;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // A ready slave beats the timeout when both land on the same cycle.
        if (bus.pready_i) begin
          state_nxt     = RESP;
          cnt_nxt       = '0;
          rsp_rdata_nxt = pwrite_q ? '0 : bus.prdata_i;
          rsp_err_nxt   = bus.pslverr_i;
          rsp_to_nxt    = 1'b0;
        end else if (TIMEOUT > 0 && cnt == TO_LAST) begin
          state_nxt     = RESP;
          cnt_nxt       = '0;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          rsp_to_nxt    = 1'b1;
        end else if (TIMEOUT > 0) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        cnt_nxt = '0;
        if (bus.rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-phase outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      psel_q      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable_q   <= (state_nxt == ACCESS);
      rsp_valid_q <= (state_nxt == RESP);
      pwrite_q    <= pwrite_nxt;
      paddr_q     <= paddr_nxt;
      pwdata_q    <= pwdata_nxt;
      pstrb_q     <= pstrb_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_to_q    <= rsp_to_nxt;
    end
  end

  assign bus.cmd_ready_o   = (state == IDLE);
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pstrb_o       = pstrb_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_to_q;
endmodule

// File: tb/tb_apb_master_param.sv
// Directed bench for apb_master_param: a 32-bit build with TIMEOUT=4 and a 16-bit build.
module tb_apb_master_param;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  apb_master_param_if #(.ADDR_W(32), .DATA_W(32)) b32();
  apb_master_param_if #(.ADDR_W(32), .DATA_W(16)) b16();

  apb_master_param #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset(reset), .bus(b32));
  apb_master_param #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(16)) dut16 (
    .clk(clk), .reset(reset), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send32(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    b32.cmd_valid_i = 1'b1;
    b32.cmd_write_i = w;
    b32.cmd_addr_i  = a;
    b32.cmd_wdata_i = d;
    b32.cmd_strb_i  = s;
    tick();
    b32.cmd_valid_i = 1'b0;
  endtask

  // Plays the slave: pready rises on ACCESS cycle index wait_n; reports what the bus did.
  task automatic mon32(input int wait_n, input logic err, input logic [31:0] rdata,
                       output int ps_n, output int pe_n, output int rsp_k, output logic addr_ok);
    logic [31:0] a0;
    ps_n = 0; pe_n = 0; rsp_k = -1; addr_ok = 1'b1;
    a0 = b32.paddr_o;
    b32.prdata_i  = rdata;
    b32.pslverr_i = err;
    for (int k = 0; k < 40; k++) begin
      if (b32.rsp_valid_o) begin
        rsp_k = k;
        break;
      end
      if (b32.psel_o) ps_n++;
      if (b32.paddr_o !== a0) addr_ok = 1'b0;
      if (b32.penable_o) begin
        pe_n++;
        b32.pready_i = (pe_n - 1 >= wait_n);
      end else begin
        b32.pready_i = 1'b0;
      end
      tick();
    end
    b32.pready_i  = 1'b0;
    b32.pslverr_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (b32.psel_o !== 1'b0 || b32.penable_o !== 1'b0) begin errors++; $display("FAIL reset_psel: psel=%b penable=%b expected 0 0", b32.psel_o, b32.penable_o); end
    checks++; if (b32.rsp_valid_o !== 1'b0 || b32.rsp_err_o !== 1'b0 || b32.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_rsp: valid=%b err=%b to=%b expected 0 0 0", b32.rsp_valid_o, b32.rsp_err_o, b32.rsp_timeout_o); end
    checks++; if (b32.paddr_o !== 32'h0 || b32.pwdata_o !== 32'h0 || b32.pstrb_o !== 4'h0 || b32.rsp_rdata_o !== 32'h0 || b32.pwrite_o !== 1'b0) begin errors++; $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h rdata=%h expected all 0", b32.paddr_o, b32.pwdata_o, b32.pstrb_o, b32.rsp_rdata_o); end
    checks++; if (b32.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", b32.cmd_ready_o); end
    checks++; if (b16.psel_o !== 1'b0 || b16.pwdata_o !== 16'h0 || b16.pstrb_o !== 2'b00) begin errors++; $display("FAIL reset16: psel=%b pwdata=%h pstrb=%b expected 0", b16.psel_o, b16.pwdata_o, b16.pstrb_o); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int ps, pe, rk; logic aok;
    b32.rsp_ready_i = 1'b0;
    send32(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    checks++; if (b32.psel_o !== 1'b1 || b32.penable_o !== 1'b0) begin errors++; $display("FAIL wr_setup: psel=%b penable=%b expected 1 0", b32.psel_o, b32.penable_o); end
    checks++; if (b32.pstrb_o !== 4'hF || b32.pwdata_o !== 32'hDEAD_BEEF || b32.pwrite_o !== 1'b1 || b32.paddr_o !== 32'h10) begin errors++; $display("FAIL wr_fields: strb=%h wdata=%h write=%b addr=%h expected F DEADBEEF 1 10", b32.pstrb_o, b32.pwdata_o, b32.pwrite_o, b32.paddr_o); end
    mon32(0, 1'b0, 32'h1234_5678, ps, pe, rk, aok);
    checks++; if (ps !== 2 || pe !== 1 || rk !== 2) begin errors++; $display("FAIL wr_timing: psel=%0d pen=%0d rsp_at=%0d expected 2 1 2", ps, pe, rk); end
    checks++; if (b32.rsp_rdata_o !== 32'h0 || b32.rsp_err_o !== 1'b0 || b32.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL wr_rsp: rdata=%h err=%b to=%b expected 0 0 0", b32.rsp_rdata_o, b32.rsp_err_o, b32.rsp_timeout_o); end
    checks++; if (b32.psel_o !== 1'b0 || b32.penable_o !== 1'b0) begin errors++; $display("FAIL wr_resp_bus: psel=%b penable=%b expected 0 0", b32.psel_o, b32.penable_o); end
    b32.rsp_ready_i = 1'b1;
    tick();
    b32.rsp_ready_i = 1'b0;
    checks++; if (b32.rsp_valid_o !== 1'b0 || b32.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL wr_done: valid=%b ready=%b expected 0 1", b32.rsp_valid_o, b32.cmd_ready_o); end
  endtask

  task automatic test_read_wait();
    int ps, pe, rk; logic aok;
    send32(1'b0, 32'h0000_0024, 32'h0, 4'hF);
    checks++; if (b32.pstrb_o !== 4'h0 || b32.pwdata_o !== 32'hDEAD_BEEF || b32.pwrite_o !== 1'b0) begin errors++; $display("FAIL rd_fields: strb=%h wdata=%h write=%b expected 0 DEADBEEF 0", b32.pstrb_o, b32.pwdata_o, b32.pwrite_o); end
    mon32(3, 1'b0, 32'h0000_00A5, ps, pe, rk, aok);
    checks++; if (pe !== 4 || rk !== 5) begin errors++; $display("FAIL rd_wait: pen=%0d rsp_at=%0d expected 4 5", pe, rk); end
    checks++; if (aok !== 1'b1 || b32.paddr_o !== 32'h24) begin errors++; $display("FAIL rd_addr_stable: stable=%b addr=%h expected 1 24", aok, b32.paddr_o); end
    checks++; if (b32.rsp_rdata_o !== 32'hA5 || b32.rsp_err_o !== 1'b0) begin errors++; $display("FAIL rd_rsp: rdata=%h err=%b expected a5 0", b32.rsp_rdata_o, b32.rsp_err_o); end
    b32.rsp_ready_i = 1'b1;
    tick();
    b32.rsp_ready_i = 1'b0;
  endtask

  task automatic test_err_backpressure();
    int ps, pe, rk; logic aok;
    send32(1'b1, 32'h0000_0030, 32'h55AA_55AA, 4'h3);
    mon32(0, 1'b1, 32'h0, ps, pe, rk, aok);
    checks++; if (rk !== 2) begin errors++; $display("FAIL bp_rsp_at: got %0d expected 2", rk); end
    for (int i = 0; i < 5; i++) begin
      b32.cmd_valid_i = 1'b1;
      b32.cmd_addr_i  = 32'h0000_0099;
      checks++; if (b32.rsp_valid_o !== 1'b1 || b32.rsp_err_o !== 1'b1 || b32.rsp_timeout_o !== 1'b0 || b32.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: valid=%b err=%b to=%b ready=%b expected 1 1 0 0", i, b32.rsp_valid_o, b32.rsp_err_o, b32.rsp_timeout_o, b32.cmd_ready_o); end
      tick();
    end
    b32.cmd_valid_i = 1'b0;
    b32.rsp_ready_i = 1'b1;
    tick();
    b32.rsp_ready_i = 1'b0;
    checks++; if (b32.rsp_valid_o !== 1'b0 || b32.cmd_ready_o !== 1'b1 || b32.psel_o !== 1'b0 || b32.paddr_o !== 32'h30) begin errors++; $display("FAIL bp_release: valid=%b ready=%b psel=%b addr=%h expected 0 1 0 30", b32.rsp_valid_o, b32.cmd_ready_o, b32.psel_o, b32.paddr_o); end
  endtask

  task automatic test_timeout();
    int ps, pe, rk; logic aok;
    send32(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    mon32(99, 1'b0, 32'hFFFF_FFFF, ps, pe, rk, aok);
    checks++; if (pe !== 4 || rk !== 5) begin errors++; $display("FAIL to_len: pen=%0d rsp_at=%0d expected 4 5", pe, rk); end
    checks++; if (b32.rsp_err_o !== 1'b1 || b32.rsp_timeout_o !== 1'b1 || b32.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL to_rsp: err=%b to=%b rdata=%h expected 1 1 0", b32.rsp_err_o, b32.rsp_timeout_o, b32.rsp_rdata_o); end
    b32.rsp_ready_i = 1'b1;
    tick();
    b32.rsp_ready_i = 1'b0;
    send32(1'b0, 32'h0000_0054, 32'h0, 4'h0);
    mon32(3, 1'b0, 32'h0000_0077, ps, pe, rk, aok);
    checks++; if (pe !== 4 || rk !== 5) begin errors++; $display("FAIL to_edge_len: pen=%0d rsp_at=%0d expected 4 5", pe, rk); end
    checks++; if (b32.rsp_err_o !== 1'b0 || b32.rsp_timeout_o !== 1'b0 || b32.rsp_rdata_o !== 32'h77) begin errors++; $display("FAIL to_edge_rsp: err=%b to=%b rdata=%h expected 0 0 77", b32.rsp_err_o, b32.rsp_timeout_o, b32.rsp_rdata_o); end
    b32.rsp_ready_i = 1'b1;
    tick();
    b32.rsp_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc = 0, last = -1, ps = 0, pe = 0, nrsp = 0;
    b32.rsp_ready_i = 1'b1;
    b32.pready_i    = 1'b1;
    b32.prdata_i    = 32'hC0DE_0000;
    for (int cyc = 0; cyc < 44; cyc++) begin
      b32.cmd_valid_i = (acc < 10);
      b32.cmd_write_i = (acc % 2 == 0);
      b32.cmd_addr_i  = 32'h100 + 32'(4 * acc);
      b32.cmd_wdata_i = 32'(acc);
      b32.cmd_strb_i  = 4'hF;
      if (b32.psel_o) ps++;
      if (b32.penable_o) pe++;
      if (b32.psel_o && !b32.penable_o) begin
        checks++; if (b32.paddr_o !== 32'h100 + 32'(4 * (acc - 1)) || b32.pwrite_o !== ((acc - 1) % 2 == 0)) begin errors++; $display("FAIL b2b_setup%0d: addr=%h write=%b", acc - 1, b32.paddr_o, b32.pwrite_o); end
      end
      if (b32.rsp_valid_o) begin
        nrsp++;
        checks++; if (b32.rsp_rdata_o !== (((acc - 1) % 2 == 0) ? 32'h0 : 32'hC0DE_0000)) begin errors++; $display("FAIL b2b_rdata%0d: got %h", acc - 1, b32.rsp_rdata_o); end
      end
      if (b32.cmd_ready_o && acc < 10) begin
        if (last >= 0) begin
          checks++; if (cyc - last !== 4 || b32.psel_o !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: interval=%0d psel=%b expected 4 0", acc, cyc - last, b32.psel_o); end
        end
        last = cyc;
        acc++;
      end
      tick();
    end
    b32.cmd_valid_i = 1'b0;
    b32.pready_i    = 1'b0;
    checks++; if (acc !== 10 || ps !== 20 || pe !== 10 || nrsp !== 10) begin errors++; $display("FAIL b2b_totals: acc=%0d psel=%0d pen=%0d rsp=%0d expected 10 20 10 10", acc, ps, pe, nrsp); end
  endtask

  task automatic test_reset_mid();
    send32(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    tick();
    checks++; if (b32.penable_o !== 1'b1) begin errors++; $display("FAIL rst_in_access: penable=%b expected 1", b32.penable_o); end
    reset = 1'b0;
    tick();
    checks++; if (b32.psel_o !== 1'b0 || b32.penable_o !== 1'b0 || b32.rsp_valid_o !== 1'b0 || b32.paddr_o !== 32'h0) begin errors++; $display("FAIL rst_abort: psel=%b pen=%b valid=%b addr=%h expected 0 0 0 0", b32.psel_o, b32.penable_o, b32.rsp_valid_o, b32.paddr_o); end
    reset = 1'b1;
    tick();
    checks++; if (b32.cmd_ready_o !== 1'b1 || b32.psel_o !== 1'b0) begin errors++; $display("FAIL rst_ready: ready=%b psel=%b expected 1 0", b32.cmd_ready_o, b32.psel_o); end
    repeat (6) tick();
    checks++; if (b32.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: valid=%b expected 0", b32.rsp_valid_o); end
  endtask

  task automatic test_data16();
    b16.pready_i    = 1'b1;
    b16.rsp_ready_i = 1'b0;
    b16.prdata_i    = 16'hBEEF;
    b16.cmd_valid_i = 1'b1;
    b16.cmd_write_i = 1'b1;
    b16.cmd_addr_i  = 32'h40;
    b16.cmd_wdata_i = 16'h1234;
    b16.cmd_strb_i  = 2'b10;
    tick();
    b16.cmd_valid_i = 1'b0;
    checks++; if (b16.psel_o !== 1'b1 || b16.pstrb_o !== 2'b10 || b16.pwdata_o !== 16'h1234) begin errors++; $display("FAIL d16_wr: psel=%b strb=%b wdata=%h expected 1 10 1234", b16.psel_o, b16.pstrb_o, b16.pwdata_o); end
    tick(); tick();
    checks++; if (b16.rsp_valid_o !== 1'b1 || b16.rsp_rdata_o !== 16'h0) begin errors++; $display("FAIL d16_wr_rsp: valid=%b rdata=%h expected 1 0", b16.rsp_valid_o, b16.rsp_rdata_o); end
    b16.rsp_ready_i = 1'b1;
    tick();
    b16.rsp_ready_i = 1'b0;
    b16.cmd_valid_i = 1'b1;
    b16.cmd_write_i = 1'b0;
    b16.cmd_wdata_i = 16'h0;
    tick();
    b16.cmd_valid_i = 1'b0;
    checks++; if (b16.pstrb_o !== 2'b00 || b16.pwdata_o !== 16'h1234) begin errors++; $display("FAIL d16_rd_fields: strb=%b wdata=%h expected 00 1234", b16.pstrb_o, b16.pwdata_o); end
    tick(); tick();
    checks++; if (b16.rsp_valid_o !== 1'b1 || b16.rsp_rdata_o !== 16'hBEEF) begin errors++; $display("FAIL d16_rd_rsp: valid=%b rdata=%h expected 1 beef", b16.rsp_valid_o, b16.rsp_rdata_o); end
    b16.rsp_ready_i = 1'b1;
    tick();
    b16.rsp_ready_i = 1'b0;
    b16.pready_i    = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    b32.cmd_valid_i = 1'b0; b32.cmd_write_i = 1'b0; b32.cmd_addr_i = '0;
    b32.cmd_wdata_i = '0;   b32.cmd_strb_i  = '0;   b32.rsp_ready_i = 1'b0;
    b32.pready_i    = 1'b0; b32.prdata_i    = '0;   b32.pslverr_i   = 1'b0;
    b16.cmd_valid_i = 1'b0; b16.cmd_write_i = 1'b0; b16.cmd_addr_i = '0;
    b16.cmd_wdata_i = '0;   b16.cmd_strb_i  = '0;   b16.rsp_ready_i = 1'b0;
    b16.pready_i    = 1'b0; b16.prdata_i    = '0;   b16.pslverr_i   = 1'b0;
    tick();
    test_reset();
    test_write();
    test_read_wait();
    test_err_backpressure();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_data16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
